// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : i2s_pkg
//  Description : Shared constants, the stereo sample type and the slot-to-bit
//                mapping helper for the I2S transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int SAMPLE_W      = 24;  // bits per channel sample
    localparam int SLOT_W        = 32;  // SCLK slots per channel
    localparam int FRAME_CNT_W   = 9;   // 512 master clocks per frame
    localparam int SCLK_DIV_LOG2 = 3;   // SCLK = master clock / 8
    localparam int SLOT_CNT_W    = $clog2(2 * SLOT_W);

    // Packed so that right occupies [47:24] and left [23:0].
    typedef struct packed {
        logic [SAMPLE_W-1:0] right;
        logic [SAMPLE_W-1:0] left;
    } stereo_sample_t;

    // Serial bit carried by a slot: left MSB-first in slots 0-23, right
    // MSB-first in slots 32-55, zero padding everywhere else.
    function automatic logic slot_bit(input stereo_sample_t f,
                                      input logic [SLOT_CNT_W-1:0] s);
        logic b;
        b = 1'b0;
        if (s < 6'd24)
            b = f.left[5'd23 - s[4:0]];
        else if ((s >= 6'd32) && (s < 6'd56))
            b = f.right[5'd23 - s[4:0]];
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_core_if.sv
`default_nettype none
// ============================================================================
//  Interface   : i2s_tx_core_if
//  Description : Bus-side sample write port of the I2S transmitter.
//                master : drives i_Wr_En / i_Wr_Data, observes FIFO flags
//                slave  : the transmitter core
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2s_tx_core_if;
    import i2s_pkg::*;

    logic           i_Wr_En;
    stereo_sample_t i_Wr_Data;
    logic           o_Full;
    logic           o_AlmostFull;
    logic           o_Empty;

    modport master (
        output i_Wr_En,
        output i_Wr_Data,
        input  o_Full,
        input  o_AlmostFull,
        input  o_Empty
    );

    modport slave (
        input  i_Wr_En,
        input  i_Wr_Data,
        output o_Full,
        output o_AlmostFull,
        output o_Empty
    );

endinterface
`default_nettype wire

// File: rtl/i2s_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_sample_fifo
//  Description : Synchronous first-word-fall-through FIFO of stereo samples.
//                Flags are registered from the next-state count, so they
//                change in the cycle after the push/pop that causes them.
//  Ports       : clk, rst_n (async, active low), i_wr_en/i_wr_data push,
//                i_rd_en pop, o_rd_data head entry, o_full/o_afull/o_empty
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_LVL = 15
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire                   i_wr_en,
    input  wire stereo_sample_t   i_wr_data,
    input  wire                   i_rd_en,
    output stereo_sample_t        o_rd_data,
    output logic                  o_full,
    output logic                  o_afull,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    stereo_sample_t r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_count_nxt;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign w_push      = i_wr_en & ~o_full;
    assign w_pop       = i_rd_en & ~o_empty;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign o_rd_data   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            o_full   <= 1'b0;
            o_afull  <= 1'b0;
            o_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            o_full  <= (w_count_nxt == CW'(DEPTH));
            o_afull <= (w_count_nxt >= CW'(AFULL_LVL));
            o_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/i2s_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_core
//  Description : Single-clock I2S transmitter. A stereo sample FIFO feeds a
//                24-bit serializer; MCLK/SCLK/LRCK are derived from a
//                free-running 9-bit frame counter (512 clocks per frame).
//  Ports       : i_MasterClk, i_Rst_n (async, active low)
//                bus (i2s_tx_core_if.slave): sample writes + FIFO flags
//                o_ReqNextData, o_SDIN, o_SCLK, o_LRCK, o_MCLK
//  Config      : I2S_LJ_FORMAT_EN defined -> left-justified LRCK timing;
//                undefined -> standard I2S (LRCK one SCLK ahead of MSB)
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_core
    import i2s_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AFULL_LVL  = 15
) (
    input  wire             i_MasterClk,
    input  wire             i_Rst_n,
    i2s_tx_core_if.slave    bus,
    output logic            o_ReqNextData,
    output logic            o_SDIN,
    output logic            o_SCLK,
    output logic            o_LRCK,
    output logic            o_MCLK
);

    logic [FRAME_CNT_W-1:0]   r_cnt;
    stereo_sample_t           r_frame;

    logic [SLOT_CNT_W-1:0]    w_slot;
    logic [SCLK_DIV_LOG2-1:0] w_phase;
    logic                     w_load;
    logic                     w_lrck_nxt;
    stereo_sample_t           w_fifo_head;

    assign w_slot  = r_cnt[FRAME_CNT_W-1:SCLK_DIV_LOG2];
    assign w_phase = r_cnt[SCLK_DIV_LOG2-1:0];
    assign w_load  = (r_cnt == '1);

`ifdef I2S_LJ_FORMAT_EN
    assign w_lrck_nxt = w_slot[SLOT_CNT_W-1];
`else
    // Word select leads the data by one slot: it reflects the next slot.
    logic [SLOT_CNT_W-1:0] w_slot_p1;
    assign w_slot_p1  = w_slot + SLOT_CNT_W'(1);
    assign w_lrck_nxt = w_slot_p1[SLOT_CNT_W-1];
`endif

    // The FIFO only pops when non-empty, so a load on an empty FIFO leaves
    // it untouched and the frame register takes silence instead.
    i2s_sample_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) u_fifo (
        .clk       (i_MasterClk),
        .rst_n     (i_Rst_n),
        .i_wr_en   (bus.i_Wr_En),
        .i_wr_data (bus.i_Wr_Data),
        .i_rd_en   (w_load),
        .o_rd_data (w_fifo_head),
        .o_full    (bus.o_Full),
        .o_afull   (bus.o_AlmostFull),
        .o_empty   (bus.o_Empty)
    );

    // Every output is registered from the current counter value, giving a
    // uniform one-cycle latency between cnt and the pins.
    always_ff @(posedge i_MasterClk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_cnt         <= '0;
            r_frame       <= '0;
            o_ReqNextData <= 1'b0;
            o_SDIN        <= 1'b0;
            o_SCLK        <= 1'b0;
            o_LRCK        <= 1'b0;
            o_MCLK        <= 1'b0;
        end else begin
            r_cnt         <= r_cnt + FRAME_CNT_W'(1);
            o_MCLK        <= r_cnt[0];
            o_SCLK        <= r_cnt[SCLK_DIV_LOG2-1];
            o_LRCK        <= w_lrck_nxt;
            o_ReqNextData <= w_load;
            if (w_load)
                r_frame <= bus.o_Empty ? '0 : w_fifo_head;
            // Phase 0 is the SCLK falling edge, where data may change.
            if (w_phase == '0)
                o_SDIN <= slot_bit(r_frame, w_slot);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx_core
//  Description : Self-checking bench for i2s_tx_core. A frame-level model
//                (sample queue, 64-slot bit vector, counter arithmetic)
//                predicts every output each cycle.
//  Config      : I2S_LJ_FORMAT_EN selects the left-justified LRCK model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_core;

    logic clk;
    logic rst_n;
    logic req, sdin, sclk, lrck, mclk;

    i2s_tx_core_if bus();

    i2s_tx_core #(.FIFO_DEPTH(16), .AFULL_LVL(15)) dut (
        .i_MasterClk   (clk),
        .i_Rst_n       (rst_n),
        .bus           (bus),
        .o_ReqNextData (req),
        .o_SDIN        (sdin),
        .o_SCLK        (sclk),
        .o_LRCK        (lrck),
        .o_MCLK        (mclk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [47:0] m_q[$];
    logic [47:0] m_frame;
    int          m_cnt;      // counter value the DUT holds now
    int          m_prev;     // counter value the outputs reflect
    logic        m_sdin;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cnt %0d)", tag, obs, exp, m_prev);
        end
    endtask

    function automatic logic m_bit(input logic [47:0] f, input int slot);
        logic [63:0] v;
        v = {f[23:0], 8'h00, f[47:24], 8'h00};
        return v[63 - slot];
    endfunction

    task automatic check_outputs();
        int   slot;
        logic exp_lrck;
        slot = m_prev / 8;
`ifdef I2S_LJ_FORMAT_EN
        exp_lrck = (slot >= 32);
`else
        exp_lrck = (((slot + 1) % 64) >= 32);
`endif
        chk("MCLK",  mclk, 1'((m_prev % 2) == 1));
        chk("SCLK",  sclk, 1'(((m_prev / 4) % 2) == 1));
        chk("LRCK",  lrck, exp_lrck);
        chk("REQ",   req,  1'(m_prev == 511));
        chk("SDIN",  sdin, m_sdin);
        chk("EMPTY", bus.o_Empty,      1'(m_q.size() == 0));
        chk("FULL",  bus.o_Full,       1'(m_q.size() == 16));
        chk("AFULL", bus.o_AlmostFull, 1'(m_q.size() >= 15));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_frame = '0;
        m_cnt   = 0;
        m_prev  = 0;
        m_sdin  = 1'b0;
    endtask

    // One clock: drive inputs, advance the model across the edge, check.
    task automatic tick(input logic wr, input logic [47:0] data);
        int  cur;
        bit  was_full;
        bus.i_Wr_En   = wr;
        bus.i_Wr_Data = data;
        @(posedge clk);
        cur      = m_cnt;
        was_full = (m_q.size() == 16);
        if (cur % 8 == 0) m_sdin = m_bit(m_frame, cur / 8);
        if (cur == 511) begin
            if (m_q.size() > 0) m_frame = m_q.pop_front();
            else                m_frame = '0;
        end
        if (wr && !was_full) m_q.push_back(data);
        m_prev = cur;
        m_cnt  = (cur + 1) % 512;
        @(negedge clk);
        bus.i_Wr_En = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0);
    endtask

    task automatic goto_cnt(input int target);
        for (int i = 0; i < 512 && m_cnt != target; i++) tick(1'b0, '0);
    endtask

    function automatic logic [47:0] rnd48();
        return {24'($urandom), 24'($urandom)};
    endfunction

    task automatic check_in_reset();
        chk("RST_SDIN",  sdin, 1'b0);
        chk("RST_SCLK",  sclk, 1'b0);
        chk("RST_LRCK",  lrck, 1'b0);
        chk("RST_MCLK",  mclk, 1'b0);
        chk("RST_REQ",   req,  1'b0);
        chk("RST_EMPTY", bus.o_Empty, 1'b1);
        chk("RST_FULL",  bus.o_Full,  1'b0);
        chk("RST_AFULL", bus.o_AlmostFull, 1'b0);
    endtask

    initial begin
        bus.i_Wr_En   = 1'b0;
        bus.i_Wr_Data = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_in_reset();
        rst_n = 1'b1;

        // Idle: silence, clock periods, request pulses, empty FIFO
        idle(1100);

        // Single directed sample ahead of a frame load
        goto_cnt(100);
        tick(1'b1, {24'h5A5A5A, 24'hC3C3C3});
        idle(1100);

        // Fill to 17 writes right after a load, then drain 16 frames
        goto_cnt(2);
        for (int i = 0; i < 17; i++) tick(1'b1, rnd48());
        idle(17 * 512 + 100);

        // Underrun with a write coincident with the load
        goto_cnt(511);
        tick(1'b1, rnd48());
        idle(1100);

        // Random traffic, fast enough to saturate the FIFO
        for (int i = 0; i < 6000; i++)
            tick(1'($urandom_range(0, 99) == 0), rnd48());

        // Asynchronous reset in the middle of a frame
        goto_cnt(200);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_in_reset();
        repeat (3) @(negedge clk);
        check_in_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 1100; i++)
            tick(1'($urandom_range(0, 199) == 0), rnd48());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
